// File: rtl/fifo_pkg.sv
// Shared sizing constants and the pointer wrap helper for the circular FIFO controller.
package fifo_pkg;

    localparam int ADDR_W_DEF    = 8;
    localparam int DEPTH_DEF     = 2 ** ADDR_W_DEF;
    localparam int COUNT_W_DEF   = ADDR_W_DEF + 1;
    localparam int AF_MARGIN_DEF = 4;
    localparam int AE_MARGIN_DEF = 4;

    // Advances a w-bit pointer by one, wrapping DEPTH-1 back to 0.
    function automatic logic [31:0] ptr_inc(input logic [31:0] p, input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (p + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrapping address counter with increment and synchronous clear; used for both RAM ports.
module fifo_ptr_ctr
    import fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ADDR_W'(ptr_inc(32'(ptr), ADDR_W));
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Circular FIFO sequencer for a single-clock dual-port RAM: pointers, occupancy,
// registered status flags, read-data validity and sticky overflow/underflow.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int AF_MARGIN = AF_MARGIN_DEF,
    parameter int AE_MARGIN = AE_MARGIN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              flush,
    input  logic              clr_err,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_ptr,
    output logic              r_en,
    output logic [ADDR_W-1:0] r_ptr,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full_flag,
    output logic              empty_flag,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam int              CW      = ADDR_W + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_TH   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0]   AE_TH   = CW'(AE_MARGIN);

    // Requests are level-sensitive and accepted in the cycle they are seen;
    // w_en/r_en are the acceptance strobes, and RAM read data is qualified by
    // rd_valid exactly one cycle after r_en.
    logic          wr_acc;
    logic          rd_acc;
    logic [CW-1:0] count_nxt;

    assign wr_acc = wr_req & ~full_flag & ~flush;
    assign rd_acc = rd_req & ~empty_flag & ~flush;
    assign w_en   = wr_acc;
    assign r_en   = rd_acc;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CW'(1);
        end
    end

    fifo_ptr_ctr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_acc),
        .clr   (flush),
        .ptr   (w_ptr)
    );

    fifo_ptr_ctr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_acc),
        .clr   (flush),
        .ptr   (r_ptr)
    );

    // Flags follow count_nxt so they line up with the count they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count        <= '0;
            full_flag    <= 1'b0;
            empty_flag   <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
        end else begin
            count        <= count_nxt;
            full_flag    <= (count_nxt == DEPTH_C);
            empty_flag   <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_TH);
            almost_empty <= (count_nxt <= AE_TH);
            rd_valid     <= rd_acc;
        end
    end

    // Errors survive flush; a new error event wins over clr_err in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~clr_err) | (wr_req & full_flag);
            underflow <= (underflow & ~clr_err) | (rd_req & empty_flag);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: queue-based reference model, bench-side RAM,
// and a decoupled monitor that scores read data against an expected queue.
module tb_fifo_ctrl;

    localparam int DEPTH = 256;

    logic       clk;
    logic       rst_n;
    logic       wr_req;
    logic       rd_req;
    logic       flush;
    logic       clr_err;
    logic       w_en;
    logic [7:0] w_ptr;
    logic       r_en;
    logic [7:0] r_ptr;
    logic       rd_valid;
    logic [8:0] count;
    logic       full_flag;
    logic       empty_flag;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    logic [7:0] wdata;
    logic [7:0] data_out;
    logic [7:0] ram [DEPTH];

    int checks;
    int failures;

    // reference model: FIFO contents as a queue, plus spec-level pointers and errors
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         m_wp;
    int         m_rp;
    bit         m_ov;
    bit         m_un;
    bit         m_rv;

    fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .flush        (flush),
        .clr_err      (clr_err),
        .w_en         (w_en),
        .w_ptr        (w_ptr),
        .r_en         (r_en),
        .r_ptr        (r_ptr),
        .rd_valid     (rd_valid),
        .count        (count),
        .full_flag    (full_flag),
        .empty_flag   (empty_flag),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bench-side dual-port RAM driven by the controller's strobes
    always @(posedge clk) begin
        if (w_en) ram[w_ptr] <= wdata;
        if (r_en) data_out <= ram[r_ptr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every rd_valid must match the oldest outstanding expected read
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", 1, 0);
            end else begin
                check("data_out", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_state();
        int n;
        n = mq.size();
        check("count",        int'(count),        n);
        check("full_flag",    int'(full_flag),    int'(n == DEPTH));
        check("empty_flag",   int'(empty_flag),   int'(n == 0));
        check("almost_full",  int'(almost_full),  int'(n >= DEPTH - 4));
        check("almost_empty", int'(almost_empty), int'(n <= 4));
        check("w_ptr",        int'(w_ptr),        m_wp);
        check("r_ptr",        int'(r_ptr),        m_rp);
        check("rd_valid",     int'(rd_valid),     int'(m_rv));
        check("overflow",     int'(overflow),     int'(m_ov));
        check("underflow",    int'(underflow),    int'(m_un));
    endtask

    // driver: one clock of stimulus, model update, and post-edge state check
    task automatic step(input bit rs, input bit wr, input bit rd, input bit fl,
                        input bit ce, input logic [7:0] d);
        bit wa;
        bit ra;
        @(negedge clk);
        rst_n   = ~rs;
        wr_req  = wr;
        rd_req  = rd;
        flush   = fl;
        clr_err = ce;
        wdata   = d;
        #1;
        wa = wr && !fl && (mq.size() < DEPTH);
        ra = rd && !fl && (mq.size() > 0);
        if (rs) begin
            mq.delete();
            m_wp = 0;
            m_rp = 0;
            m_ov = 0;
            m_un = 0;
            m_rv = 0;
        end else begin
            check("w_en", int'(w_en), int'(wa));
            check("r_en", int'(r_en), int'(ra));
            m_ov = (m_ov && !ce) || (wr && mq.size() == DEPTH);
            m_un = (m_un && !ce) || (rd && mq.size() == 0);
            m_rv = ra;
            if (fl) begin
                mq.delete();
                m_wp = 0;
                m_rp = 0;
            end else begin
                if (ra) begin
                    exp_q.push_back(mq.pop_front());
                    m_rp = (m_rp + 1) % DEPTH;
                end
                if (wa) begin
                    mq.push_back(d);
                    m_wp = (m_wp + 1) % DEPTH;
                end
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 8'($urandom_range(0, 255)));
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, 8'd0);
    endtask

    task automatic random_phase(input int n, input int wr_pct, input int rd_pct);
        bit wr;
        bit rd;
        bit fl;
        bit ce;
        for (int i = 0; i < n; i++) begin
            wr = ($urandom_range(0, 99) < wr_pct);
            rd = ($urandom_range(0, 99) < rd_pct);
            fl = ($urandom_range(0, 299) == 0);
            ce = ($urandom_range(0, 39) == 0);
            step(0, wr, rd, fl, ce, 8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        flush    = 1'b0;
        clr_err  = 1'b0;
        wdata    = 8'd0;
        m_wp     = 0;
        m_rp     = 0;
        m_ov     = 0;
        m_un     = 0;
        m_rv     = 0;

        // reset for two cycles, with requests asserted to show reset wins
        step(1, 1, 1, 0, 0, 8'd0);
        step(1, 0, 0, 0, 0, 8'd0);

        // fill to full, then one extra write: rejected, overflow sets, w_ptr wrapped to 0
        write_n(DEPTH);
        write_n(1);

        // full with both requests: only the read is taken
        step(0, 1, 1, 0, 0, 8'h5a);

        // drain fully, then empty with both requests: only the write is taken
        read_n(DEPTH - 1);
        read_n(1);
        step(0, 1, 1, 0, 0, 8'ha5);
        read_n(1);

        // fill with 1..8 and read them back in order
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 0, 0, 8'(i));
        read_n(8);

        // hold count at 10 with simultaneous read and write for 5 cycles
        write_n(10);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 8'($urandom_range(0, 255)));
        read_n(10);

        // reach count=100 with w_ptr=250, then flush with wr_req; errors must survive
        step(0, 0, 0, 1, 0, 8'd0);
        write_n(250);
        read_n(150);
        step(0, 1, 0, 1, 0, 8'h11);
        step(0, 0, 0, 0, 0, 8'd0);

        // clr_err alone, then clr_err colliding with a fresh underflow event
        step(0, 0, 0, 0, 1, 8'd0);
        step(0, 0, 1, 0, 1, 8'd0);
        step(0, 0, 0, 0, 1, 8'd0);

        // randomized traffic swinging between full and empty
        for (int r = 0; r < 2; r++) begin
            random_phase(700, 75, 25);
            random_phase(700, 25, 75);
        end
        random_phase(300, 50, 50);

        // reset in the middle of traffic
        write_n(20);
        step(1, 1, 1, 0, 0, 8'h33);
        random_phase(200, 60, 40);

        step(0, 0, 0, 0, 0, 8'd0);
        step(0, 0, 0, 0, 0, 8'd0);
        step(0, 0, 0, 0, 0, 8'd0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
